// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (I) and
// data access (D). Data wins arbitration, but after MAX_D_BURST consecutive D
// grants with a fetch waiting, the fetch is served once. Every output is a
// flop; each transaction walks IDLE -> BUSY_x -> RESP -> IDLE.
module mem_port_arbiter #(
  parameter int DATA_W      = 32,
  parameter int MAX_D_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_sel,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_D_BURST + 1);
  localparam logic [CNT_W-1:0] DCNT_MAX = CNT_W'(MAX_D_BURST);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  dcnt_q, dcnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_sel_q, mem_sel_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  // Saturating increment of the consecutive-D-grant counter.
  function automatic logic [CNT_W-1:0] dcnt_inc(input logic [CNT_W-1:0] c);
    dcnt_inc = (c == DCNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  // Arbitration, transaction sequencing and next values of all outputs.
  always_comb begin
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    mem_req_d   = mem_req_q;
    mem_sel_d   = mem_sel_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (d_req && !(i_req && dcnt_q == DCNT_MAX)) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_sel_d   = 1'b1;
          mem_we_d    = d_we;
          mem_wdata_d = d_wdata;
          // The counter only measures D grants made while a fetch waits.
          dcnt_d      = i_req ? dcnt_inc(dcnt_q) : '0;
        end else if (i_req) begin
          state_d   = BUSY_I;
          mem_req_d = 1'b1;
          mem_sel_d = 1'b0;
          mem_we_d  = 1'b0;
          dcnt_d    = '0;
        end else begin
          dcnt_d = '0;
        end
      end
      BUSY_I: begin
        if (mem_ready) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          i_ack_d   = 1'b1;
          i_rdata_d = mem_rdata;
        end
      end
      BUSY_D: begin
        if (mem_ready) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          d_ack_d   = 1'b1;
          d_rdata_d = mem_rdata;
        end
      end
      RESP: begin
        // One dead cycle lets requesters see the ack before re-arbitration.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset clears everything, data included,
  // so every output starts at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dcnt_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_sel_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      mem_req_q   <= mem_req_d;
      mem_sel_q   <= mem_sel_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_sel   = mem_sel_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule
